// File: rtl/ov7670_capture.sv
// OV7670 camera bus receiver: samples vsync/href/D on pclk and assembles bytes into pixels with x/y and sof/eol/eof.
// Define OV7670_CAPTURE_ERR_EN to build the line/frame checkers that drive frame_err (tied to 0 otherwise).

module ov7670_capture #(
    parameter int  RESOLUTION_WIDTH  = 640,
    parameter int  RESOLUTION_HEIGHT = 480,
    parameter int  BYTES_PER_PIXEL   = 2,
    localparam int XW = (RESOLUTION_WIDTH > 1) ? $clog2(RESOLUTION_WIDTH) : 1,
    localparam int YW = (RESOLUTION_HEIGHT > 1) ? $clog2(RESOLUTION_HEIGHT) : 1,
    localparam int PW = 8 * BYTES_PER_PIXEL
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    D,
    output logic [PW-1:0] pixel,
    output logic          pixel_valid,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          sof,
    output logic          eol,
    output logic          eof,
    output logic          frame_err,
    output logic [1:0]    state_dbg_o
);
    localparam int LINE_BYTES = RESOLUTION_WIDTH * BYTES_PER_PIXEL;
    localparam int BCW        = $clog2(LINE_BYTES) + 1;
    localparam int CW         = $clog2(RESOLUTION_WIDTH) + 1;
    localparam int LCW        = $clog2(RESOLUTION_HEIGHT) + 1;

    typedef enum logic [1:0] {
        WAIT_VSYNC = 2'd0,
        SYNC       = 2'd1,
        FRAME      = 2'd2
    } state_e;

    state_e          state_q;
    logic            vsync_q, vsync_qq, href_q, href_qq;
    logic [7:0]      d_q, hi_q;
    logic [BCW-1:0]  byte_cnt_q;
    logic [CW-1:0]   col_q;
    logic [LCW-1:0]  line_cnt_q;
    logic            phase_q;
    logic [PW-1:0]   pixel_q;
    logic            pixel_valid_q, sof_q, eol_q, eof_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;

    logic            vs_rise, vs_fall, href_fall, in_byte, cap, last_phase, at_eol;
    logic [PW-1:0]   pix_asm;

    assign vs_rise    = vsync_q & ~vsync_qq;
    assign vs_fall    = ~vsync_q & vsync_qq;
    assign href_fall  = ~href_q & href_qq;
    // href while vsync is high never counts as line data
    assign in_byte    = (state_q == FRAME) & href_q & ~vsync_q;
    assign cap        = in_byte & (byte_cnt_q < BCW'(LINE_BYTES))
                      & (line_cnt_q < LCW'(RESOLUTION_HEIGHT));
    assign last_phase = (BYTES_PER_PIXEL == 1) | phase_q;
    assign at_eol     = (col_q == CW'(RESOLUTION_WIDTH - 1));

    generate
        if (BYTES_PER_PIXEL == 2) begin : g_two_byte
            assign pix_asm = {hi_q, d_q};
        end else begin : g_one_byte
            assign pix_asm = d_q;
        end
    endgenerate

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_VSYNC;
            vsync_q       <= 1'b0;
            vsync_qq      <= 1'b0;
            href_q        <= 1'b0;
            href_qq       <= 1'b0;
            d_q           <= '0;
            hi_q          <= '0;
            byte_cnt_q    <= '0;
            col_q         <= '0;
            line_cnt_q    <= '0;
            phase_q       <= 1'b0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            eof_q         <= 1'b0;
        end else begin
            vsync_q       <= vsync;
            vsync_qq      <= vsync_q;
            href_q        <= href;
            href_qq       <= href_q;
            d_q           <= D;
            pixel_valid_q <= 1'b0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            eof_q         <= 1'b0;
            case (state_q)
                WAIT_VSYNC: begin
                    if (vs_rise) state_q <= SYNC;
                end
                SYNC: begin
                    if (vs_fall) begin
                        state_q    <= FRAME;
                        byte_cnt_q <= '0;
                        col_q      <= '0;
                        line_cnt_q <= '0;
                        phase_q    <= 1'b0;
                        y_q        <= '0;
                    end
                end
                FRAME: begin
                    if (vs_rise) state_q <= SYNC;
                    // keeps counting past a full line so over-long lines are visible to the checker
                    if (in_byte && byte_cnt_q != '1) byte_cnt_q <= byte_cnt_q + BCW'(1);
                    if (cap) begin
                        if (!last_phase) begin
                            hi_q    <= d_q;
                            phase_q <= 1'b1;
                        end else begin
                            pixel_q       <= pix_asm;
                            pixel_valid_q <= 1'b1;
                            x_q           <= col_q[XW-1:0];
                            y_q           <= line_cnt_q[YW-1:0];
                            sof_q         <= (col_q == '0) && (line_cnt_q == '0);
                            eol_q         <= at_eol;
                            eof_q         <= at_eol && (line_cnt_q == LCW'(RESOLUTION_HEIGHT - 1));
                            col_q         <= col_q + CW'(1);
                            phase_q       <= 1'b0;
                        end
                    end
                    if (href_fall) begin
                        byte_cnt_q <= '0;
                        col_q      <= '0;
                        phase_q    <= 1'b0;
                        if (line_cnt_q != LCW'(RESOLUTION_HEIGHT)) line_cnt_q <= line_cnt_q + LCW'(1);
                    end
                end
                default: state_q <= WAIT_VSYNC;
            endcase
        end
    end

`ifdef OV7670_CAPTURE_ERR_EN
    logic hv_err_q, extra_q, frame_err_q, line_bad, frame_bad;

    assign line_bad  = (byte_cnt_q != BCW'(LINE_BYTES)) | phase_q;
    assign frame_bad = (line_cnt_q != LCW'(RESOLUTION_HEIGHT)) | extra_q | hv_err_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hv_err_q    <= 1'b0;
            extra_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= (state_q == FRAME) & ((href_fall & line_bad) | (vs_rise & frame_bad));
            if (state_q == WAIT_VSYNC) begin
                hv_err_q <= 1'b0;
                extra_q  <= 1'b0;
            end else begin
                // href seen during a vsync pulse is reported at the end of the frame that follows it
                if (state_q == FRAME && vs_rise) hv_err_q <= 1'b0;
                if (vsync_q && href_q) hv_err_q <= 1'b1;
                if (state_q == SYNC && vs_fall) extra_q <= 1'b0;
                else if (state_q == FRAME && href_fall && line_cnt_q == LCW'(RESOLUTION_HEIGHT))
                    extra_q <= 1'b1;
            end
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign pixel       = pixel_q;
    assign pixel_valid = pixel_valid_q;
    assign x           = x_q;
    assign y           = y_q;
    assign sof         = sof_q;
    assign eol         = eol_q;
    assign eof         = eof_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: a W=4/H=2/BPP=2 instance and a W=4/H=1/BPP=1 instance share the camera inputs.
// Expected pixels and line stimulus come from tables; reset and error timing use hand-written sequences.

module tb_ov7670_capture;

`ifdef OV7670_CAPTURE_ERR_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic        pclk  = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        href  = 1'b0;
    logic [7:0]  D     = '0;

    logic [15:0] a_pixel;
    logic        a_valid, a_sof, a_eol, a_eof, a_err;
    logic [1:0]  a_x, a_state;
    logic [0:0]  a_y;
    logic [7:0]  b_pixel;
    logic        b_valid, b_sof, b_eol, b_eof, b_err;
    logic [1:0]  b_x, b_state;
    logic [0:0]  b_y;

    ov7670_capture #(.RESOLUTION_WIDTH(4), .RESOLUTION_HEIGHT(2), .BYTES_PER_PIXEL(2)) dut_a (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .D(D),
        .pixel(a_pixel), .pixel_valid(a_valid), .x(a_x), .y(a_y),
        .sof(a_sof), .eol(a_eol), .eof(a_eof), .frame_err(a_err), .state_dbg_o(a_state)
    );

    ov7670_capture #(.RESOLUTION_WIDTH(4), .RESOLUTION_HEIGHT(1), .BYTES_PER_PIXEL(1)) dut_b (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .D(D),
        .pixel(b_pixel), .pixel_valid(b_valid), .x(b_x), .y(b_y),
        .sof(b_sof), .eol(b_eol), .eof(b_eof), .frame_err(b_err), .state_dbg_o(b_state)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [15:0] pix;
        int          x;
        int          y;
        logic [2:0]  mk;
        int          cyc;
    } mon_t;

    typedef struct {
        int          test;
        logic [15:0] pix;
        int          x;
        int          y;
        logic [2:0]  mk;
    } exp_t;

    typedef struct {
        int test;
        int first;
        int n;
    } line_t;

    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    int     rise_cyc, last_byte_cyc;
    int     fall_q[$];
    int     err_a[$], err_b[$];
    mon_t   mon_a[$], mon_b[$];
    exp_t   exps[$];
    line_t  lines[$];
    logic   prev_valid = 1'b0;
    mon_t   m;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // monitor: samples 1 time unit after each rising edge
    always @(posedge pclk) begin
        cyc++;
        #1;
        if (a_valid) begin
            m.pix = a_pixel; m.x = int'(a_x); m.y = int'(a_y);
            m.mk = {a_sof, a_eol, a_eof}; m.cyc = cyc;
            mon_a.push_back(m);
            check("valid_gap", prev_valid, 0);
        end else begin
            check("markers_idle", {a_sof, a_eol, a_eof}, 0);
        end
        if (b_valid) begin
            m.pix = {8'h00, b_pixel}; m.x = int'(b_x); m.y = int'(b_y);
            m.mk = {b_sof, b_eol, b_eof}; m.cyc = cyc;
            mon_b.push_back(m);
        end
        if (a_err) err_a.push_back(cyc);
        if (b_err) err_b.push_back(cyc);
        prev_valid = a_valid;
    end

    task automatic add_exp(input int t, input logic [15:0] p, input int xx, input int yy,
                           input logic s, input logic e, input logic f);
        exp_t r;
        r.test = t; r.pix = p; r.x = xx; r.y = yy; r.mk = {s, e, f};
        exps.push_back(r);
    endtask

    task automatic add_line(input int t, input int first, input int n);
        line_t l;
        l.test = t; l.first = first; l.n = n;
        lines.push_back(l);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            href = 1'b0;
        end
    endtask

    task automatic vsync_pulse();
        @(negedge pclk);
        href = 1'b0; vsync = 1'b1;
        rise_cyc = cyc + 2;
        repeat (3) @(negedge pclk);
        vsync = 1'b0;
        idle(3);
    endtask

    task automatic send_line(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            href = 1'b1; D = 8'(first + i);
            last_byte_cyc = cyc + 2;
        end
        @(negedge pclk);
        href = 1'b0; D = '0;
        fall_q.push_back(cyc + 2);
        idle(2);
    endtask

    task automatic run_lines(input int t);
        foreach (lines[i]) if (lines[i].test == t) send_line(lines[i].first, lines[i].n);
    endtask

    task automatic clear_logs();
        mon_a.delete(); mon_b.delete(); err_a.delete(); err_b.delete(); fall_q.delete();
    endtask

    task automatic check_pixels(input int t, input bit use_b);
        mon_t got[$];
        int   n_exp = 0;
        int   k = 0;
        if (use_b) got = mon_b; else got = mon_a;
        foreach (exps[i]) if (exps[i].test == t) n_exp++;
        check($sformatf("t%0d_count", t), got.size(), n_exp);
        foreach (exps[i]) begin
            if (exps[i].test == t) begin
                if (k < got.size()) begin
                    check($sformatf("t%0d_pix%0d", t, k), got[k].pix, exps[i].pix);
                    check($sformatf("t%0d_x%0d", t, k), got[k].x, exps[i].x);
                    check($sformatf("t%0d_y%0d", t, k), got[k].y, exps[i].y);
                    check($sformatf("t%0d_sof_eol_eof%0d", t, k), got[k].mk, exps[i].mk);
                end
                k++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int t1_last, exp_err_cyc;

        add_line(1, 'h00, 8); add_line(1, 'h08, 8);
        add_line(3, 'h10, 7); add_line(3, 'h20, 8);
        add_line(4, 'h30, 8); add_line(4, 'h40, 8); add_line(4, 'h50, 8);
        add_line(5, 'hA0, 4);
        add_line(2, 'h60, 8); add_line(2, 'h68, 8);

        add_exp(1, 'h0001, 0, 0, 1, 0, 0); add_exp(1, 'h0203, 1, 0, 0, 0, 0);
        add_exp(1, 'h0405, 2, 0, 0, 0, 0); add_exp(1, 'h0607, 3, 0, 0, 1, 0);
        add_exp(1, 'h0809, 0, 1, 0, 0, 0); add_exp(1, 'h0A0B, 1, 1, 0, 0, 0);
        add_exp(1, 'h0C0D, 2, 1, 0, 0, 0); add_exp(1, 'h0E0F, 3, 1, 0, 1, 1);
        add_exp(3, 'h1011, 0, 0, 1, 0, 0); add_exp(3, 'h1213, 1, 0, 0, 0, 0);
        add_exp(3, 'h1415, 2, 0, 0, 0, 0); add_exp(3, 'h2021, 0, 1, 0, 0, 0);
        add_exp(3, 'h2223, 1, 1, 0, 0, 0); add_exp(3, 'h2425, 2, 1, 0, 0, 0);
        add_exp(3, 'h2627, 3, 1, 0, 1, 1);
        add_exp(4, 'h3031, 0, 0, 1, 0, 0); add_exp(4, 'h3233, 1, 0, 0, 0, 0);
        add_exp(4, 'h3435, 2, 0, 0, 0, 0); add_exp(4, 'h3637, 3, 0, 0, 1, 0);
        add_exp(4, 'h4041, 0, 1, 0, 0, 0); add_exp(4, 'h4243, 1, 1, 0, 0, 0);
        add_exp(4, 'h4445, 2, 1, 0, 0, 0); add_exp(4, 'h4647, 3, 1, 0, 1, 1);
        add_exp(5, 'h00A0, 0, 0, 1, 0, 0); add_exp(5, 'h00A1, 1, 0, 0, 0, 0);
        add_exp(5, 'h00A2, 2, 0, 0, 0, 0); add_exp(5, 'h00A3, 3, 0, 0, 1, 1);
        add_exp(2, 'h6061, 0, 0, 1, 0, 0); add_exp(2, 'h6263, 1, 0, 0, 0, 0);
        add_exp(2, 'h6465, 2, 0, 0, 0, 0); add_exp(2, 'h6667, 3, 0, 0, 1, 0);
        add_exp(2, 'h6869, 0, 1, 0, 0, 0); add_exp(2, 'h6A6B, 1, 1, 0, 0, 0);
        add_exp(2, 'h6C6D, 2, 1, 0, 0, 0); add_exp(2, 'h6E6F, 3, 1, 0, 1, 1);

        // reset state
        repeat (3) @(negedge pclk);
        check("rst_pixel", a_pixel, 0);
        check("rst_valid", a_valid, 0);
        check("rst_xy", {a_x, a_y}, 0);
        check("rst_markers", {a_sof, a_eol, a_eof, a_err}, 0);
        check("rst_state", a_state, 0);
        check("rst_b_pixel", b_pixel, 0);
        rst_n = 1'b1;
        idle(2);
        vsync_pulse();

        // nominal 4x2 frame
        run_lines(1);
        t1_last = last_byte_cyc;
        vsync_pulse();
        idle(4);
        check_pixels(1, 0);
        check("t1_latency", (mon_a.size() > 0) ? mon_a[mon_a.size()-1].cyc : -1, t1_last);
        check("t1_err_cnt", err_a.size(), 0);
        clear_logs();

        // short first line
        run_lines(3);
        vsync_pulse();
        idle(4);
        check_pixels(3, 0);
        exp_err_cyc = (ERR_EN != 0) ? fall_q[0] : 0;
        check("t3_err_cnt", err_a.size(), ERR_EN);
        check("t3_err_cyc", (err_a.size() > 0) ? err_a[0] : 0, exp_err_cyc);
        clear_logs();

        // one line too many
        run_lines(4);
        vsync_pulse();
        idle(4);
        check_pixels(4, 0);
        exp_err_cyc = (ERR_EN != 0) ? rise_cyc : 0;
        check("t4_err_cnt", err_a.size(), ERR_EN);
        check("t4_err_cyc", (err_a.size() > 0) ? err_a[0] : 0, exp_err_cyc);
        clear_logs();

        // single-byte pixels on the second instance
        run_lines(5);
        vsync_pulse();
        idle(4);
        check_pixels(5, 1);
        for (int i = 1; i < mon_b.size(); i++)
            check($sformatf("t5_back_to_back%0d", i), mon_b[i].cyc - mon_b[0].cyc, i);
        check("t5_b_err_cnt", err_b.size(), 0);
        clear_logs();

        // reset in the middle of line 1
        send_line('h70, 8);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            href = 1'b1; D = 8'('h78 + i);
        end
        @(negedge pclk);
        rst_n = 1'b0; D = 8'h7B;
        #1;
        check("t2_rst_valid", a_valid, 0);
        check("t2_rst_pixel", a_pixel, 0);
        check("t2_rst_state", a_state, 0);
        check("t2_rst_xy", {a_x, a_y}, 0);
        clear_logs();
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            D = 8'('h7C + i);
        end
        @(negedge pclk);
        rst_n = 1'b1; D = 8'h7E;
        @(negedge pclk);
        D = 8'h7F;
        idle(3);
        send_line('h90, 8);
        check("t2_quiet", mon_a.size(), 0);
        vsync_pulse();
        run_lines(2);
        vsync_pulse();
        idle(4);
        check_pixels(2, 0);
        check("t2_err_cnt", err_a.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
